// File: rtl/cordic_polar_to_rect.sv
// Iterative CORDIC rotation engine: (mag, angle) -> signed (x, y), valid/ready on both sides.
// Define CORDIC_GAIN_COMP_EN to pre-scale the start vector by 1/K so outputs land at mag*cos/sin.
module cordic_polar_to_rect #(
  parameter int ITER = 10,
  parameter int FRAC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] mag,
  input  logic [7:0] angle,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] x_out,
  output logic [9:0] y_out
);

  typedef enum logic [1:0] {IDLE, ROT, FIX, DONE} state_t;

  localparam logic signed [18:0] HALF = 19'sd1 <<< (FRAC - 1);
  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  state_t             state_reg, state_next;
  logic signed [17:0] x_reg, y_reg;
  logic signed [15:0] z_reg;
  logic [1:0]         q_reg;
  logic [3:0]         iter_reg;
  logic [9:0]         x_out_reg, y_out_reg;

  logic signed [17:0] x_init;
  logic signed [17:0] x_shift, y_shift, x_rot, y_rot;
  logic signed [15:0] z_rot, atan_val;
  logic signed [18:0] xr, yr, qx, qy;

  // arctan(2^-i) with a full circle mapped to 65536
  function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'sd8192;
      4'd1:    return 16'sd4836;
      4'd2:    return 16'sd2555;
      4'd3:    return 16'sd1297;
      4'd4:    return 16'sd651;
      4'd5:    return 16'sd326;
      4'd6:    return 16'sd163;
      4'd7:    return 16'sd81;
      4'd8:    return 16'sd41;
      4'd9:    return 16'sd20;
      4'd10:   return 16'sd10;
      4'd11:   return 16'sd5;
      default: return 16'sd0;
    endcase
  endfunction

  function automatic logic [9:0] sat_round(input logic signed [18:0] v);
    logic signed [18:0] r;
    r = (v + HALF) >>> FRAC;
    if (r > 19'sd511)
      return 10'h1FF;
    else if (r < -19'sd512)
      return 10'h200;
    else
      return r[9:0];
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  logic [17:0] mag_prod;
  assign mag_prod = 18'(mag) * 18'd311;
  assign x_init   = signed'(mag_prod >> (9 - FRAC));
`else
  assign x_init = signed'(18'(mag) << FRAC);
`endif

  // one micro-rotation; direction follows the sign of the residual angle
  always_comb begin
    atan_val = atan_lut(iter_reg);
    x_shift  = x_reg >>> iter_reg;
    y_shift  = y_reg >>> iter_reg;
    if (!z_reg[15]) begin
      x_rot = x_reg - y_shift;
      y_rot = y_reg + x_shift;
      z_rot = z_reg - atan_val;
    end else begin
      x_rot = x_reg + y_shift;
      y_rot = y_reg - x_shift;
      z_rot = z_reg + atan_val;
    end
  end

  always_comb begin
    xr = {x_reg[17], x_reg};
    yr = {y_reg[17], y_reg};
    qx = xr;
    qy = yr;
    case (q_reg)
      2'd0: begin qx = xr;  qy = yr;  end
      2'd1: begin qx = -yr; qy = xr;  end
      2'd2: begin qx = -xr; qy = -yr; end
      2'd3: begin qx = yr;  qy = -xr; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = ROT;
      ROT:  if (iter_reg == LAST_ITER) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      q_reg     <= '0;
      iter_reg  <= '0;
      x_out_reg <= '0;
      y_out_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            // residual within the quadrant; 90 degrees = 16384
            q_reg    <= angle[7:6];
            z_reg    <= signed'({2'b00, angle[5:0], 8'h00});
            x_reg    <= x_init;
            y_reg    <= '0;
            iter_reg <= '0;
          end
        end
        ROT: begin
          x_reg    <= x_rot;
          y_reg    <= y_rot;
          z_reg    <= z_rot;
          iter_reg <= iter_reg + 4'd1;
        end
        FIX: begin
          x_out_reg <= sat_round(qx);
          y_out_reg <= sat_round(qy);
        end
        default: ;
      endcase
    end
  end

  assign x_out = x_out_reg;
  assign y_out = y_out_reg;

endmodule
